pipe_stage: RTL and testbench
=============================

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter WIDTH, default 32, payload bits carried per beat (1..256).
REQ-002 Parameter CNT_W, default 16, width of each performance counter.
REQ-003 Port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 Port nRST  input  1  asynchronous, active-low reset.
REQ-005 Port in_valid  input  1  upstream beat present.
REQ-006 Port in_ready  output  1  stage accepts the beat this cycle.
REQ-007 Port in_data  input  WIDTH  upstream payload.
REQ-008 Port out_valid  output  1  downstream beat present.
REQ-009 Port out_ready  input  1  downstream accepts the beat; low means stall.
REQ-010 Port out_data  output  WIDTH  downstream payload.
REQ-011 Port flush  input  1  discard all held and incoming beats.
REQ-012 Port cnt_clr  input  1  synchronous clear of both counters.
REQ-013 Port bubble_cnt  output  CNT_W  cycles with out_valid low.
REQ-014 Port stall_cnt  output  CNT_W  cycles with out_valid high and out_ready low.

Function
REQ-015 A transfer occurs on an edge where valid and ready are both high on that side.
REQ-016 States: EMPTY (no beat), FULL (one beat in main register), SKID (main plus skid register full; SKID_EN only).
REQ-017 EMPTY: in transfer -> FULL, out_data = in_data, out_valid high next cycle; latency one cycle.
REQ-018 FULL: out transfer with simultaneous in transfer -> stay FULL with new data; out transfer only -> EMPTY; neither -> hold data unchanged.
REQ-019 out_data and out_valid SHALL stay stable while out_valid high and out_ready low.
REQ-020 flush high -> next state EMPTY, out_data zeroed, any incoming beat that edge dropped; flush overrides all other events.
REQ-021 flush SHALL not affect counters.
REQ-022 bubble_cnt increments each cycle out_valid low; stall_cnt increments each cycle out_valid high and out_ready low; both saturate at all-ones, no wrap.
REQ-023 cnt_clr high -> both counters 0 next edge, overriding increment that cycle.
REQ-024 No beat SHALL be duplicated or lost except by flush.

Reset
REQ-025 nRST low asynchronously forces state EMPTY, out_valid 0, out_data 0, skid register 0, bubble_cnt 0, stall_cnt 0.
REQ-026 in_ready SHALL be 0 while nRST low; reset mid-transfer discards the beat.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN selects the ready path.
REQ-028 Without it: in_ready = out_ready OR NOT out_valid, combinational; state SKID unused.
REQ-029 With it: in_ready is registered, high in EMPTY/FULL, low in SKID; FULL with in transfer and out_ready low -> SKID, beat stored in skid register.
REQ-030 With it: SKID with out transfer -> FULL, skid beat moves to main register next edge; order preserved.

Structure
REQ-031 Shared package holds the state enumeration type (EMPTY, FULL, SKID) and the default WIDTH and CNT_W constants.
REQ-032 Sub-module pipe_stage_cnt implements one saturating clearable counter, instantiated twice.
REQ-033 Existing fixed-field pipeline latches SHALL be replaceable by one pipe_stage with packed payload; enable low maps to flush.

Verification
REQ-034 Reset, in_valid=1 in_data=0xA5A5A5A5, out_ready=1 -> out_valid=1, out_data=0xA5A5A5A5 one cycle later.
REQ-035 Stream 0x1,0x2,0x3 with out_ready low two cycles mid-stream -> output exactly 0x1,0x2,0x3 in order, stall_cnt=2.
REQ-036 FULL holding 0x7, flush with in_valid=1 in_data=0x9 -> next cycle out_valid=0, out_data=0; 0x9 never emitted.
REQ-037 CNT_W=4, out_valid low 20 cycles -> bubble_cnt=15; cnt_clr one cycle -> bubble_cnt=0.
REQ-038 SKID_EN, out_ready low, push 0x11,0x22 -> in_ready low after second; out_ready high -> 0x11 then 0x22, in_ready high again.
REQ-039 nRST asserted while FULL with 0xFF -> out_valid=0, out_data=0 immediately, no clock edge needed.

Source files
------------

// File: rtl/pipe_stage_pkg.sv
// pipe_stage shared types: occupancy states and default widths.
// Optional skid buffer is selected with PIPE_STAGE_SKID_EN.
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/pipe_stage_cnt.sv
// Saturating performance counter with synchronous clear.
// Clear wins over increment in the same cycle.
module pipe_stage_cnt #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register with flush and bubble/stall counters.
// Define PIPE_STAGE_SKID_EN for a registered in_ready with a skid slot.
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_n;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_n;
    logic             in_xfer;
    logic             out_xfer;

    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;

`ifdef PIPE_STAGE_SKID_EN
    // Ready depends on held state only, cutting the out_ready path.
    assign in_ready = nRST & (state != SKID);
`else
    assign in_ready = nRST & (out_ready | ~out_valid);
`endif

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_n;
            main_q <= main_n;
            skid_q <= skid_n;
        end
    end

    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = EMPTY;
            main_n  = '0;
            skid_n  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state_n = FULL;
                        main_n  = in_data;
                    end
                end
                FULL: begin
                    if (in_xfer && out_xfer) begin
                        main_n = in_data;
                    end else if (out_xfer) begin
                        state_n = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_xfer) begin
                        state_n = SKID;
                        skid_n  = in_data;
`endif
                    end
                end
                SKID: begin
                    if (out_xfer) begin
                        state_n = FULL;
                        main_n  = skid_q;
                    end
                end
                default: begin
                    state_n = EMPTY;
                end
            endcase
        end
    end

    pipe_stage_cnt #(.W(CNT_W)) u_bubble (
        .CLK  (CLK),
        .nRST (nRST),
        .clr  (cnt_clr),
        .inc  (~out_valid),
        .cnt  (bubble_cnt)
    );

    pipe_stage_cnt #(.W(CNT_W)) u_stall (
        .CLK  (CLK),
        .nRST (nRST),
        .clr  (cnt_clr),
        .inc  (out_valid & ~out_ready),
        .cnt  (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_pipe_stage;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID_B = 1'b1;
`else
    localparam bit SKID_B = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        flush = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [15:0] bubble_cnt;
    logic [15:0] stall_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_data;
    logic [3:0]  s_bubble;
    logic [3:0]  s_stall;

    int total = 0;
    int bad = 0;

    logic [31:0] mq[$];
    logic [31:0] hold;
    int          mb;
    int          ms;

    always #5 CLK = ~CLK;

    pipe_stage #(.WIDTH(32), .CNT_W(16)) u_dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .bubble_cnt (bubble_cnt),
        .stall_cnt  (stall_cnt)
    );

    pipe_stage #(.WIDTH(32), .CNT_W(4)) u_small (
        .CLK        (CLK),
        .nRST       (nRST),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .in_data    (in_data),
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .out_data   (s_out_data),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .bubble_cnt (s_bubble),
        .stall_cnt  (s_stall)
    );

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [31:0] od;
        logic [15:0] bub;
        logic [15:0] stl;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        flush = 1'b0;
        cnt_clr = 1'b0;
        mq.delete();
        hold = '0;
        mb = 0;
        ms = 0;
        @(posedge CLK);
        #1;
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_od", 64'(out_data), 64'd0);
        chk("rst_ir", 64'(in_ready), 64'd0);
        chk("rst_bub", 64'(bubble_cnt), 64'd0);
        chk("rst_stl", 64'(stall_cnt), 64'd0);
        nRST = 1'b1;
    endtask

    task automatic rstep(input logic iv, input logic [31:0] d,
                         input logic ordy, input logic fl,
                         input logic clr);
        bit mrdy;
        in_valid = iv;
        in_data = d;
        out_ready = ordy;
        flush = fl;
        cnt_clr = clr;
        #1;
        if (SKID_B)
            mrdy = (mq.size() < 2);
        else
            mrdy = (mq.size() == 0) || ordy;
        chk("rnd_ir", 64'(in_ready), 64'(mrdy));
        if (clr) begin
            mb = 0;
            ms = 0;
        end else begin
            if (mq.size() == 0 && mb < 65535) mb++;
            if (mq.size() != 0 && !ordy && ms < 65535) ms++;
        end
        if (fl) begin
            mq.delete();
            hold = '0;
        end else begin
            if (mq.size() != 0 && ordy) hold = mq.pop_front();
            if (iv && mrdy) mq.push_back(d);
        end
        @(posedge CLK);
        #1;
        chk("rnd_ov", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0)
            chk("rnd_od", 64'(out_data), 64'(mq[0]));
        else
            chk("rnd_od", 64'(out_data), 64'(hold));
        chk("rnd_bub", 64'(bubble_cnt), 64'(mb));
        chk("rnd_stl", 64'(stall_cnt), 64'(ms));
    endtask

    task automatic drive(input logic iv, input logic [31:0] d,
                         input logic ordy, input logic fl);
        in_valid = iv;
        in_data = d;
        out_ready = ordy;
        flush = fl;
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'hA5A5A5A5, 1'b1, 1'b0, 1'b1, 32'hA5A5A5A5, 16'd1, 16'd0};
        tbl[1] = '{1'b1, 32'h1, 1'b1, 1'b0, 1'b1, 32'h1, 16'd1, 16'd0};
        tbl[2] = '{1'b1, 32'h2, 1'b0, 1'b0, 1'b1, 32'h1, 16'd1, 16'd1};
        tbl[3] = '{1'b1, 32'h2, 1'b0, 1'b0, 1'b1, 32'h1, 16'd1, 16'd2};
        tbl[4] = '{1'b1, 32'h2, 1'b1, 1'b0, 1'b1, 32'h2, 16'd1, 16'd2};
        tbl[5] = '{1'b1, 32'h3, 1'b1, 1'b0, 1'b1, 32'h3, 16'd1, 16'd2};
        tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h3, 16'd1, 16'd2};
        tbl[7] = '{1'b1, 32'h7, 1'b0, 1'b0, 1'b1, 32'h7, 16'd2, 16'd2};
        tbl[8] = '{1'b1, 32'h9, 1'b0, 1'b1, 1'b0, 32'h0, 16'd2, 16'd3};
        tbl[9] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 16'd3, 16'd3};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            @(posedge CLK);
            #1;
            chk($sformatf("tbl%0d_ov", i), 64'(out_valid), 64'(tbl[i].ov));
            chk($sformatf("tbl%0d_od", i), 64'(out_data), 64'(tbl[i].od));
            chk($sformatf("tbl%0d_bub", i), 64'(bubble_cnt), 64'(tbl[i].bub));
            chk($sformatf("tbl%0d_stl", i), 64'(stall_cnt), 64'(tbl[i].stl));
        end

        // Bubble saturation on the narrow counter, then clear.
        do_reset();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (20) @(posedge CLK);
        #1;
        chk("sat_small", 64'(s_bubble), 64'd15);
        chk("sat_wide", 64'(bubble_cnt), 64'd20);
        cnt_clr = 1'b1;
        @(posedge CLK);
        #1;
        cnt_clr = 1'b0;
        chk("clr_small", 64'(s_bubble), 64'd0);
        chk("clr_wide", 64'(bubble_cnt), 64'd0);
        @(posedge CLK);
        #1;
        chk("clr_resume", 64'(bubble_cnt), 64'd1);

        // Asynchronous reset while holding a beat.
        drive(1'b1, 32'hFF, 1'b0, 1'b0);
        @(posedge CLK);
        #1;
        chk("ar_full_od", 64'(out_data), 64'hFF);
        #2;
        nRST = 1'b0;
        #1;
        chk("ar_ov", 64'(out_valid), 64'd0);
        chk("ar_od", 64'(out_data), 64'd0);
        chk("ar_ir", 64'(in_ready), 64'd0);

        // Backpressure on a second push.
        do_reset();
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        #1;
        chk("bp_ir0", 64'(in_ready), 64'd1);
        @(posedge CLK);
        #1;
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        #1;
        chk("bp_ir1", 64'(in_ready), 64'(SKID_B));
        @(posedge CLK);
        #1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("bp_ir2", 64'(in_ready), 64'd0);
        chk("bp_od0", 64'(out_data), 64'h11);
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        if (SKID_B) begin
            chk("bp_ov1", 64'(out_valid), 64'd1);
            chk("bp_od1", 64'(out_data), 64'h22);
            chk("bp_ir3", 64'(in_ready), 64'd1);
            @(posedge CLK);
            #1;
        end
        chk("bp_ov2", 64'(out_valid), 64'd0);
        chk("bp_ir4", 64'(in_ready), 64'd1);

        // Randomized traffic against the queue model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rstep(($urandom_range(0, 3) != 0), $urandom,
                  ($urandom_range(0, 4) > 1),
                  ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 63) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
